shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational 32-bit shifter between NREQ requesters, e.g. the ALU shift path and the load/store byte-alignment path.
- Round-robin arbitration with a valid/ready request handshake.
- The result is registered into a single-entry response slot, tagged with the requester id, and held until that requester accepts it.
- Sits in the riscv32i execute stage, in front of the existing shifter datapath.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 1, requester-id width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*32  operand for requester i, in bits [32i+31:32i].
- req_shamt  in  NREQ*5  shift amount for requester i.
- req_shtype  in  NREQ*2  shift type for requester i: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
- rsp_valid  out  NREQ  response valid; at most one bit set, selecting the owner.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_y  out  32  registered shift result.
- rsp_id  out  IDW  id of the requester that owns rsp_y.

Behaviour:
- Reset, synchronous and active-high:
  - rsp_valid=0, rsp_y=0, rsp_id=0, rr_ptr=0, state=IDLE.
  - req_ready is 0 during the reset cycle.
  - A pending result at reset is discarded and never delivered.
- States:
  - IDLE: slot empty.
  - FULL: slot holds a result not yet accepted.
- Slot free condition: slot_free = (state==IDLE) | (rsp_valid[rsp_id] & rsp_ready[rsp_id]).
- Grant:
  - When slot_free, search req_valid starting at index rr_ptr, wrapping modulo NREQ. The first set index g gets req_ready[g]=1 in the same cycle (combinational).
  - No other req_ready bit is set.
  - If not slot_free, req_ready=0.
- Handshake: a transfer occurs when req_valid[g] & req_ready[g].
- On a transfer at edge N:
  - rsp_y <= shift(a_g, shamt_g, shtype_g).
  - rsp_id <= g; rsp_valid <= onehot(g); state <= FULL.
  - rr_ptr <= (g+1) mod NREQ.
- Latency: the result is visible in the cycle after the request is accepted (1 cycle).
- Throughput: 1 per cycle. Draining the slot and accepting a new request in the same cycle is legal; rsp_valid stays high with the new id and data.
- Drain with no new transfer: rsp_valid <= 0, state <= IDLE. rsp_y and rsp_id keep their stale values.
- While FULL and not drained: rsp_y, rsp_id and rsp_valid hold steady.
- rsp_ready from a non-owner is ignored.
- req_valid may drop without a grant; no state change results.
- rr_ptr changes only on a transfer.
- Shift arithmetic, 32-bit result, shamt 0..31 with no wrap:
  - SLL zero-fills.
  - SRL zero-fills.
  - SRA replicates a[31].
  - 11 passes a unchanged.

Decomposition:
- Package shift_pkg holds:
  - the shtype constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_PASS=2'b11;
  - the state encoding ST_IDLE / ST_FULL.
- One sub-module: instantiate the existing `shifter` datapath on the granted operand mux output. The arbiter contains no shift logic of its own.
- The round-robin pick is a function inside shift_arbiter, not a separate module.

Test Plan:
- Reset then single request: req0 a=0x0000_00F0, shamt=4, SLL, rsp_ready held 1 -> cycle+1: rsp_valid=01, rsp_id=0, rsp_y=0x0000_0F00; the next cycle rsp_valid=00.
- Arithmetic vs logical shift: req1 a=0x8000_0010, shamt=4. SRA -> rsp_y=0xF800_0001; SRL -> 0x0800_0001; shtype 11 -> 0x8000_0010; SLL with shamt=31 on 0x3 -> 0x8000_0000.
- Contention: both req_valid held with rsp_ready=11 -> grants alternate 0,1,0,1 on consecutive cycles; throughput 1/cycle; rsp_id matches the grant order.
- Backpressure: owner rsp_ready=0 for 3 cycles with req_valid asserted -> req_ready=00, and rsp_y/rsp_id stay stable for all 3 cycles. The non-owner asserting rsp_ready has no effect. The owner then accepts and the next grant issues in that same cycle.
- Reset mid-operation: slot FULL with rsp_valid=10, assert rst one cycle -> next cycle rsp_valid=00, rsp_y=0, rr_ptr=0. A subsequent simultaneous req0 and req1 grants req0 first.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice.
//   SH_* : shift-type encodings carried on req_shtype.
//   state_e : response-slot occupancy.
package shift_pkg;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,  // slot empty
    ST_FULL = 1'b1   // slot holds an unaccepted result
  } state_e;

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit shifter datapath.
//   a_i      : operand
//   shamt_i  : shift amount 0..31
//   shtype_i : SH_SLL / SH_SRL / SH_SRA / SH_PASS
//   y_o      : result
module shifter
  import shift_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  input  logic [1:0]  shtype_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (shtype_i)
      SH_SLL:  y_o = a_i << shamt_i;
      SH_SRL:  y_o = a_i >> shamt_i;
      SH_SRA:  y_o = $unsigned($signed(a_i) >>> shamt_i);
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between NREQ requesters.
//   clk, rst   : clock, synchronous active-high reset
//   req_*      : per-requester valid/ready request with operand, shamt, shtype
//   rsp_valid  : one-hot owner of the registered result (or zero)
//   rsp_ready  : per-requester accept; only the owner's bit matters
//   rsp_y      : registered shift result
//   rsp_id     : id of the requester owning rsp_y
// NREQ must be 2..4 and IDW must equal clog2(NREQ).
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_a,
  input  logic [NREQ*5-1:0]   req_shamt,
  input  logic [NREQ*2-1:0]   req_shtype,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [31:0]         rsp_y,
  output logic [IDW-1:0]      rsp_id
);

  // Returns {found, index} of the first set valid bit at or after ptr, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] res;
    int unsigned  idx;
    res = '0;
    // Walk the search order backwards so the earliest hit is written last.
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (valid[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_y_q, rsp_y_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  logic [IDW:0]    pick;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic            drain;
  logic            slot_free;
  logic            xfer;
  logic [31:0]     op_a;
  logic [4:0]      op_shamt;
  logic [1:0]      op_shtype;
  logic [31:0]     shift_y;

  always_comb begin
    pick      = rr_pick(req_valid, rr_ptr_q);
    grant_vld = pick[IDW];
    grant_id  = pick[IDW-1:0];
    drain     = rsp_valid_q[rsp_id_q] & rsp_ready[rsp_id_q];
    slot_free = (state_q == ST_IDLE) | drain;
    req_ready = '0;
    if (!rst && slot_free && grant_vld) req_ready[grant_id] = 1'b1;
    xfer      = |(req_valid & req_ready);
  end

  // Operand mux feeding the shared shifter.
  always_comb begin
    op_a      = '0;
    op_shamt  = '0;
    op_shtype = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_id == IDW'(i)) begin
        op_a      = req_a[i*32 +: 32];
        op_shamt  = req_shamt[i*5 +: 5];
        op_shtype = req_shtype[i*2 +: 2];
      end
    end
  end

  shifter u_shifter (
    .a_i      (op_a),
    .shamt_i  (op_shamt),
    .shtype_i (op_shtype),
    .y_o      (shift_y)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    if (xfer) begin
      state_d               = ST_FULL;
      rsp_valid_d           = '0;
      rsp_valid_d[grant_id] = 1'b1;
      rsp_y_d               = shift_y;
      rsp_id_d              = grant_id;
      rr_ptr_d              = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (drain) begin
      // Stale rsp_y / rsp_id are intentionally left in place.
      state_d     = ST_IDLE;
      rsp_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model of the response slot.
module tb_shift_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*5-1:0]   req_shamt;
  logic [NREQ*2-1:0]   req_shtype;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         rsp_y;
  logic [IDW-1:0]      rsp_id;

  always #5 clk = ~clk;

  shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_shamt  (req_shamt),
    .req_shtype (req_shtype),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_id     (rsp_id)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 1'b0;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_y;
  int          m_ptr;

  function automatic logic [31:0] model_shift(input logic [31:0] a, input int sh,
                                              input logic [1:0] t);
    logic [63:0] w;
    case (t)
      2'b00: begin w = {32'b0, a} << sh; return w[31:0]; end
      2'b01: begin w = {32'b0, a} >> sh; return w[31:0]; end
      2'b10: begin w = {{32{a[31]}}, a} >> sh; return w[31:0]; end
      default: return a;
    endcase
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit model_free();
    return !m_valid || rsp_ready[m_id];
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    if (rst || !model_free()) return r;
    g = model_grant(req_valid);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_id    = 0;
      m_y     = '0;
      m_ptr   = 0;
    end else if (m_known) begin
      int g;
      g = model_grant(req_valid);
      if (model_free() && g >= 0) begin
        m_y     = model_shift(req_a[g*32 +: 32], int'(req_shamt[g*5 +: 5]),
                              req_shtype[g*2 +: 2]);
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && rsp_ready[m_id]) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known && !done) begin
      logic [NREQ-1:0] ev;
      ev = '0;
      if (m_valid) ev[m_id] = 1'b1;
      check("model req_ready", 32'(req_ready), 32'(exp_ready()));
      check("model rsp_valid", 32'(rsp_valid), 32'(ev));
      check("model rsp_id",    32'(rsp_id),    32'(m_id));
      check("model rsp_y",     rsp_y,          m_y);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [4:0] sh,
                         input logic [1:0] t);
    req_a[i*32 +: 32]    = a;
    req_shamt[i*5 +: 5]  = sh;
    req_shtype[i*2 +: 2] = t;
  endtask

  initial begin
    logic [31:0] held_y;
    rst        = 1'b1;
    req_valid  = '0;
    rsp_ready  = '0;
    req_a      = '0;
    req_shamt  = '0;
    req_shtype = '0;
    tick();
    check("reset req_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_y",     rsp_y,          32'h0);
    check("reset rsp_id",    32'(rsp_id),    32'h0);

    // Single request, SLL.
    set_req(0, 32'h0000_00F0, 5'd4, 2'b00);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("single grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("single rsp_valid", 32'(rsp_valid), 32'h1);
    check("single rsp_id",    32'(rsp_id),    32'h0);
    check("single rsp_y",     rsp_y,          32'h0000_0F00);
    tick();
    @(negedge clk);
    check("single drained", 32'(rsp_valid), 32'h0);

    // Shift types on requester 1, back to back.
    tick();
    set_req(1, 32'h8000_0010, 5'd4, 2'b10);
    req_valid = 2'b10;
    @(negedge clk);
    check("req1 grant", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 32'h8000_0010, 5'd4, 2'b01);
    @(negedge clk);
    check("sra rsp_y", rsp_y, 32'hF800_0001);
    check("b2b grant", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 32'h8000_0010, 5'd4, 2'b11);
    @(negedge clk);
    check("srl rsp_y", rsp_y, 32'h0800_0001);
    tick();
    set_req(1, 32'h0000_0003, 5'd31, 2'b00);
    @(negedge clk);
    check("pass rsp_y", rsp_y, 32'h8000_0010);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("sll31 rsp_y", rsp_y, 32'h8000_0000);
    check("sll31 rsp_id", 32'(rsp_id), 32'h1);

    // Contention: grants alternate 0,1,0,1.
    tick();
    set_req(0, 32'h0000_0011, 5'd1, 2'b00);
    set_req(1, 32'h0000_0100, 5'd4, 2'b01);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("contend grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        check("contend rsp_id", 32'(rsp_id), 32'((k - 1) % 2));
        check("contend rsp_y", rsp_y, (k % 2 == 1) ? 32'h22 : 32'h10);
      end
      tick();
    end

    // Backpressure: owner is requester 1; only non-owner asserts ready.
    rsp_ready = 2'b01;
    @(negedge clk);
    held_y = 32'h10;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("bp req_ready", 32'(req_ready), 32'h0);
      check("bp rsp_valid", 32'(rsp_valid), 32'h2);
      check("bp rsp_id",    32'(rsp_id),    32'h1);
      check("bp rsp_y",     rsp_y,          held_y);
      tick();
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    check("release grant", 32'(req_ready), 32'h1);
    tick();

    // Reset mid-operation with slot owned by requester 1.
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    @(negedge clk);
    check("pre-rst rsp_y", rsp_y, 32'h22);
    check("pre-rst grant", 32'(req_ready), 32'h2);
    tick();
    rst       = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    @(negedge clk);
    check("rst full rsp_valid", 32'(rsp_valid), 32'h2);
    check("rst req_ready",      32'(req_ready), 32'h0);
    tick();
    rst       = 1'b0;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("post-rst rsp_valid", 32'(rsp_valid), 32'h0);
    check("post-rst rsp_y",     rsp_y,          32'h0);
    check("post-rst rsp_id",    32'(rsp_id),    32'h0);
    check("post-rst grant",     32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    check("post-rst first id", 32'(rsp_id), 32'h0);
    check("post-rst first y",  rsp_y,       32'h22);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom, 5'($urandom), 2'($urandom));
    end
    tick();
    rst = 1'b0;
    done = 1'b1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
